// File: rtl/checkout_monitor.sv
// Checkout scan counter with stolen-item blink alarm; HEX digit decode when CHECKOUT_MONITOR_HEX_EN is defined.
// Key press to count update is 4 cycles (2-flop sync, edge pulse, CAPTURE); no backpressure, raw keys only.
module checkout_monitor #(
  parameter int BLINK_HALF = 4,
  parameter int CNT_W      = 4
) (
  input  logic             CLOCK_50,
  input  logic             reset_n,
  input  logic             scan_n,
  input  logic             ack_n,
  input  logic             discounted,
  input  logic             stolen,
  output logic [CNT_W-1:0] item_cnt,
  output logic [CNT_W-1:0] disc_cnt,
  output logic [CNT_W-1:0] stolen_cnt,
  output logic             alarm,
  output logic             busy,
  output logic [6:0]       HEX0,
  output logic [6:0]       HEX1,
  output logic [6:0]       HEX2
);

  localparam int              BW         = $clog2(BLINK_HALF + 1);
  localparam logic [BW-1:0]   BLINK_LAST = BW'(BLINK_HALF - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {IDLE, CAPTURE, ALARM} state_t;

  state_t           r_state, w_next;
  logic [1:0]       w_keys;
  logic [1:0]       r_s1, r_s2, r_s3, r_warm, r_armed, r_pulse;
  logic             w_scan_p, w_ack_p;
  logic             r_disc, r_stol;
  logic [CNT_W-1:0] r_item, r_dcnt, r_scnt;
  logic             r_alarm, r_busy;
  logic [BW-1:0]    r_blink;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // Bit 0 is scan, bit 1 is ack. A key must be seen released after reset
  // (r_armed) before a falling edge may produce a pulse.
  assign w_keys = {ack_n, scan_n};

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_s1    <= '1;
      r_s2    <= '1;
      r_s3    <= '1;
      r_warm  <= '0;
      r_armed <= '0;
      r_pulse <= '0;
    end else begin
      r_s1    <= w_keys;
      r_s2    <= r_s1;
      r_s3    <= r_s2;
      r_warm  <= {r_warm[0], 1'b1};
      r_armed <= r_armed | ({2{r_warm[1]}} & r_s2);
      r_pulse <= r_armed & r_s3 & ~r_s2;
    end
  end

  assign w_scan_p = r_pulse[0];
  assign w_ack_p  = r_pulse[1];

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_scan_p) w_next = CAPTURE;
      CAPTURE: w_next = r_stol ? ALARM : IDLE;
      ALARM:   if (w_ack_p) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_disc  <= 1'b0;
      r_stol  <= 1'b0;
      r_item  <= '0;
      r_dcnt  <= '0;
      r_scnt  <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != IDLE);
      if (r_state == IDLE && w_scan_p) begin
        r_disc <= discounted;
        r_stol <= stolen;
      end
      if (r_state == CAPTURE) begin
        r_item <= sat_inc(r_item);
        if (r_disc) r_dcnt <= sat_inc(r_dcnt);
        if (r_stol) r_scnt <= sat_inc(r_scnt);
      end
    end
  end

  // Alarm starts high on entry and toggles each BLINK_HALF cycles inside ALARM.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_alarm <= 1'b0;
      r_blink <= '0;
    end else if (w_next == ALARM) begin
      if (r_state != ALARM) begin
        r_alarm <= 1'b1;
        r_blink <= '0;
      end else if (r_blink == BLINK_LAST) begin
        r_alarm <= ~r_alarm;
        r_blink <= '0;
      end else begin
        r_blink <= r_blink + 1'b1;
      end
    end else begin
      r_alarm <= 1'b0;
      r_blink <= '0;
    end
  end

  assign item_cnt   = r_item;
  assign disc_cnt   = r_dcnt;
  assign stolen_cnt = r_scnt;
  assign alarm      = r_alarm;
  assign busy       = r_busy;

`ifdef CHECKOUT_MONITOR_HEX_EN
  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      4'hF: return 7'b0001110;
      default: return 7'b1111111;
    endcase
  endfunction

  assign HEX0 = seg7(4'(r_item));
  assign HEX1 = seg7(4'(r_dcnt));
  assign HEX2 = seg7(4'(r_scnt));
`else
  assign HEX0 = 7'b1111111;
  assign HEX1 = 7'b1111111;
  assign HEX2 = 7'b1111111;
`endif

endmodule

// File: tb/tb_checkout_monitor.sv
// Directed bench for checkout_monitor: timing, blink, ack priority, saturation, reset and HEX.
module tb_checkout_monitor;

`ifdef CHECKOUT_MONITOR_HEX_EN
  localparam bit HEX_ON = 1'b1;
`else
  localparam bit HEX_ON = 1'b0;
`endif

  localparam logic [6:0] SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  logic       CLOCK_50 = 1'b0;
  logic       reset_n = 1'b1, scan_n = 1'b1, ack_n = 1'b1;
  logic       discounted = 1'b0, stolen = 1'b0;
  logic [3:0] item_cnt, disc_cnt, stolen_cnt;
  logic       alarm, busy;
  logic [6:0] HEX0, HEX1, HEX2;
  int         n_checks = 0;
  int         n_err = 0;

  always #10 CLOCK_50 = ~CLOCK_50;

  checkout_monitor #(.BLINK_HALF(4), .CNT_W(4)) dut (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .scan_n(scan_n), .ack_n(ack_n),
    .discounted(discounted), .stolen(stolen),
    .item_cnt(item_cnt), .disc_cnt(disc_cnt), .stolen_cnt(stolen_cnt),
    .alarm(alarm), .busy(busy), .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2));

  function automatic logic [6:0] exp_hex(input int v);
    return HEX_ON ? SEG[v % 16] : 7'b1111111;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_counts(input string tag, input int it, input int di, input int st);
    check({tag, "_item"}, {28'b0, item_cnt}, it);
    check({tag, "_disc"}, {28'b0, disc_cnt}, di);
    check({tag, "_stol"}, {28'b0, stolen_cnt}, st);
  endtask

  task automatic check_flags(input string tag, input int al, input int bu);
    check({tag, "_alarm"}, {31'b0, alarm}, al);
    check({tag, "_busy"}, {31'b0, busy}, bu);
  endtask

  task automatic check_hex(input string tag, input int it, input int di, input int st);
    check({tag, "_hex0"}, {25'b0, HEX0}, {25'b0, exp_hex(it)});
    check({tag, "_hex1"}, {25'b0, HEX1}, {25'b0, exp_hex(di)});
    check({tag, "_hex2"}, {25'b0, HEX2}, {25'b0, exp_hex(st)});
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    #2;
  endtask

  // Press scan with the given flags; returns just after edge k+2.
  task automatic press(input logic d, input logic s);
    discounted = d;
    stolen     = s;
    scan_n     = 1'b0;
    repeat (3) step();
  endtask

  task automatic scan_full(input logic d, input logic s);
    press(d, s);
    step();
    step();
    scan_n = 1'b1;
    repeat (3) step();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #3;
    reset_n = 1'b1;
    repeat (4) step();
  endtask

  initial begin
    #1 reset_n = 1'b0;
    #1;
    check_counts("rst", 0, 0, 0);
    check_flags("rst", 0, 0);
    check_hex("rst", 0, 0, 0);
    #5 reset_n = 1'b1;
    repeat (4) step();

    // Plain scan: exact k+3 capture and k+4 count update
    press(1'b0, 1'b0);
    check_flags("t1_k2", 0, 0);
    check_counts("t1_k2", 0, 0, 0);
    step();
    check_counts("t1_k3", 0, 0, 0);
    check_flags("t1_k3", 0, 1);
    scan_n = 1'b1;
    step();
    check_counts("t1_k4", 1, 0, 0);
    check_flags("t1_k4", 0, 0);
    check_hex("t1", 1, 0, 0);
    repeat (3) step();

    // Discounted + stolen: both counters, then blinking alarm
    do_reset();
    press(1'b1, 1'b1);
    step();
    scan_n = 1'b1;
    step();
    check_counts("t2", 1, 1, 1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t2_blink%0d", i), {31'b0, alarm}, (i < 4) ? 32'd1 : 32'd0);
      check($sformatf("t2_busy%0d", i), {31'b0, busy}, 32'd1);
      step();
    end

    // Scan alone in ALARM is ignored
    scan_n = 1'b0;
    repeat (5) step();
    scan_n = 1'b1;
    check_counts("t2_ign", 1, 1, 1);
    check("t2_ign_busy", {31'b0, busy}, 32'd1);
    repeat (3) step();

    // Scan and ack together in ALARM: ack wins
    scan_n = 1'b0;
    ack_n  = 1'b0;
    repeat (3) step();
    check("t3_k2_busy", {31'b0, busy}, 32'd1);
    step();
    check_flags("t3_k3", 0, 0);
    check_counts("t3_k3", 1, 1, 1);
    step();
    step();
    check_counts("t3_k5", 1, 1, 1);
    check_flags("t3_k5", 0, 0);
    scan_n = 1'b1;
    ack_n  = 1'b1;
    repeat (3) step();

    // Saturation after 20 discounted scans
    do_reset();
    for (int i = 0; i < 20; i++) scan_full(1'b1, 1'b0);
    check_counts("t4", 15, 15, 0);
    check_hex("t4", 15, 15, 0);

    // Reset one cycle after scan_p, with key still held
    press(1'b1, 1'b1);
    step();
    check("t5_busy_pre", {31'b0, busy}, 32'd1);
    #3 reset_n = 1'b0;
    #1;
    check_counts("t5_rst", 0, 0, 0);
    check_flags("t5_rst", 0, 0);
    check_hex("t5_rst", 0, 0, 0);
    #2 reset_n = 1'b1;
    repeat (8) step();
    check_counts("t5_held", 0, 0, 0);
    check_flags("t5_held", 0, 0);
    scan_n = 1'b1;
    repeat (4) step();
    scan_full(1'b0, 1'b0);
    check_counts("t5_again", 1, 0, 0);

    // Three plain scans
    do_reset();
    for (int i = 0; i < 3; i++) scan_full(1'b0, 1'b0);
    check_counts("t6", 3, 0, 0);
    check_hex("t6", 3, 0, 0);
    check_flags("t6", 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
